io_input_port: RTL

IO_INPUT_PORT -- requirements
Module: io_input_port

---
 rtl/io_input_port_pkg.sv | 8 +
 rtl/io_input_port_debounce_bit.sv | 40 ++++
 rtl/io_input_port.sv | 86 ++++++++
 3 files changed

// File: rtl/io_input_port_pkg.sv
// Register map shared by the input port and anything that needs its offsets.
package io_in_pkg;
    localparam int         NUM_REGS     = 4;
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_EDGE     = 2'd1;
    localparam logic [1:0] REG_MASK     = 2'd2;
    localparam logic [1:0] REG_EDGE_SEL = 2'd3;
endpackage

// File: rtl/io_input_port_debounce_bit.sv
// One pin: two-flop synchronizer, stability counter and the accepted (debounced) level.
module debounce_bit #(
    parameter int DEBOUNCE_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_deb,
    output logic o_deb_next
);
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_deb;
    logic [DEBOUNCE_W-1:0] r_cnt;
    logic                  w_diff;
    logic                  w_full;

    assign w_diff = r_sync2 != r_deb;
    assign w_full = &r_cnt;
    // Exposed so the parent can flag an edge on the same clock the level is accepted.
    assign o_deb_next = (w_diff && w_full) ? r_sync2 : r_deb;
    assign o_deb      = r_deb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_deb   <= o_deb_next;
            if (w_diff && !w_full)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end
endmodule

// File: rtl/io_input_port.sv
// Memory-mapped 8-bit debounced input port with sticky edge flags, mask and level irq.
module io_input_port #(
    parameter logic [15:0] BASE_ADDR  = 16'h8401,
    parameter int          DEBOUNCE_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_clk,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_writing,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  pins_in,
    output logic [7:0]  rd_data,
    output logic        rd_sel,
    output logic        irq
);
    import io_in_pkg::*;

    logic [7:0]  w_deb;
    logic [7:0]  w_deb_next;
    logic [7:0]  w_set;
    logic [7:0]  w_clr;
    logic [7:0]  w_rd_mux;
    logic [15:0] w_off;
    logic [1:0]  w_reg;
    logic        w_hit;
    logic        w_wr;
    logic [7:0]  r_edge;
    logic [7:0]  r_mask;
    logic [7:0]  r_edge_sel;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_deb
            debounce_bit #(
                .DEBOUNCE_W (DEBOUNCE_W)
            ) u_deb (
                .clk        (clk),
                .reset      (reset),
                .i_pin      (pins_in[gi]),
                .o_deb      (w_deb[gi]),
                .o_deb_next (w_deb_next[gi])
            );
        end
    endgenerate

    // Wrapped subtraction: addresses below the base land far above NUM_REGS.
    assign w_off = cpu_addr - BASE_ADDR;
    assign w_hit = w_off < 16'(NUM_REGS);
    assign w_reg = w_off[1:0];
    assign w_wr  = ~cpu_clk & cpu_writing & w_hit;

    assign w_set = (w_deb_next & ~w_deb & ~r_edge_sel) | (~w_deb_next & w_deb & r_edge_sel);
    assign w_clr = (w_wr && w_reg == REG_EDGE) ? cpu_data_out : 8'h00;

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_reg)
            REG_DATA:     w_rd_mux = w_deb;
            REG_EDGE:     w_rd_mux = r_edge;
            REG_MASK:     w_rd_mux = r_mask;
            REG_EDGE_SEL: w_rd_mux = r_edge_sel;
            default:      w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge     <= 8'h00;
            r_mask     <= 8'h00;
            r_edge_sel <= 8'h00;
            rd_data    <= 8'h00;
            rd_sel     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            // Set has priority over a simultaneous write-1-to-clear.
            r_edge <= (r_edge & ~w_clr) | w_set;
            if (w_wr && w_reg == REG_MASK)
                r_mask <= cpu_data_out;
            if (w_wr && w_reg == REG_EDGE_SEL)
                r_edge_sel <= cpu_data_out;
            irq     <= |(r_edge & r_mask);
            rd_data <= w_hit ? w_rd_mux : 8'h00;
            rd_sel  <= w_hit;
        end
    end
endmodule
